// File: rtl/cic_comp_mac_seq.sv
// cic_comp_mac_seq: decimate-by-2, 15-tap symmetric CIC compensation FIR built
// around a single shared multiplier that walks one tap pair per cycle.
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   clk_vld_in   : strobe qualifying dat_in
//   dat_in       : signed 35-bit input sample
//   ovr_clr      : clears ovr_flag (a simultaneous set wins)
//   busy         : high while a MAC sequence is running
//   clk_vld_out  : one-cycle strobe qualifying dat_out
//   dat_out      : signed 35-bit decimated output
//   ovr_flag     : sticky, an input sample was dropped
// Build option: define CIC_COMP_SAT_EN to saturate the output instead of wrapping.
module cic_comp_mac_seq (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_vld_in,
    input  logic signed [34:0] dat_in,
    input  logic              ovr_clr,
    output logic              busy,
    output logic              clk_vld_out,
    output logic signed [34:0] dat_out,
    output logic              ovr_flag
);

    localparam int unsigned DW    = 35;  // sample / output width
    localparam int unsigned PW    = 36;  // pre-adder width
    localparam int unsigned CW    = 31;  // coefficient width
    localparam int unsigned AW    = 67;  // accumulator: 65-bit range plus two guard bits
    localparam int unsigned TAPS  = 15;
    localparam int unsigned SHIFT = 30;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]               r_state, w_state_nxt;
    logic [3:0]               r_k;
    logic signed [DW-1:0]     r_dly [TAPS];
    logic                     r_phase;
    logic                     r_hold_vld;
    logic signed [DW-1:0]     r_hold_dat;
    logic signed [AW-1:0]     r_acc, r_prod;
    logic                     r_busy, r_vld_out, r_ovr;
    logic signed [DW-1:0]     r_dat_out;

    logic                     w_idle, w_mac, w_done;
    logic                     w_start, w_shift, w_hold_cap, w_drop;
    logic signed [DW-1:0]     w_shift_dat;
    logic [2:0]               w_kk;
    logic [3:0]               w_ia, w_ib;
    logic signed [CW-1:0]     w_coef;
    logic                     w_neg;
    logic signed [PW-1:0]     w_pre;
    logic signed [AW-1:0]     w_prod, w_term;
    logic signed [DW-1:0]     w_out;

    assign busy        = r_busy;
    assign clk_vld_out = r_vld_out;
    assign dat_out     = r_dat_out;
    assign ovr_flag    = r_ovr;

    // Input acceptance: a held sample always drains before a new one enters the line.
    always_comb begin
        w_idle      = (r_state == S_IDLE);
        w_mac       = (r_state == S_MAC);
        w_done      = (r_state == S_DONE);
        w_start     = w_idle & ~r_hold_vld & clk_vld_in & r_phase;
        w_shift     = (w_idle & (r_hold_vld | clk_vld_in)) | (w_done & r_hold_vld);
        w_shift_dat = r_hold_vld ? r_hold_dat : dat_in;
        w_hold_cap  = clk_vld_in & ((w_idle & r_hold_vld) | w_done | (w_mac & ~r_hold_vld));
        w_drop      = clk_vld_in & w_mac & r_hold_vld;
    end

    // Next-state logic; MAC runs k=0..7 issue plus one cycle to fold in the last product.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_MAC;
            S_MAC:   if (r_k == 4'd8) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Tap-pair select, pre-add and the shared multiplier.
    always_comb begin
        w_kk   = r_k[2:0];
        w_ia   = {1'b0, w_kk};
        w_ib   = 4'd14 - w_ia;
        w_coef = '0;
        w_neg  = 1'b0;
        case (w_kk)
            3'd0: begin w_coef = 31'sd6421026;   w_neg = 1'b1; end
            3'd1: begin w_coef = 31'sd1088314;   w_neg = 1'b1; end
            3'd2: begin w_coef = 31'sd34811522;  w_neg = 1'b0; end
            3'd3: begin w_coef = 31'sd8641811;   w_neg = 1'b0; end
            3'd4: begin w_coef = 31'sd116533699; w_neg = 1'b1; end
            3'd5: begin w_coef = 31'sd53216433;  w_neg = 1'b1; end
            3'd6: begin w_coef = 31'sd356375486; w_neg = 1'b0; end
            default: begin w_coef = 31'sd628155438; w_neg = 1'b0; end
        endcase
        // Centre tap has no partner.
        if (w_kk == 3'd7) w_pre = PW'(r_dly[7]);
        else              w_pre = PW'(r_dly[w_ia]) + PW'(r_dly[w_ib]);
        w_prod = AW'(w_pre) * AW'(w_coef);
        w_term = w_neg ? -w_prod : w_prod;
    end

    // Output scaling by 2^-30.
`ifdef CIC_COMP_SAT_EN
    localparam logic signed [AW-1:0] OUT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] OUT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
    logic signed [AW-1:0] w_acc_sh;
    always_comb begin
        w_acc_sh = r_acc >>> SHIFT;
        w_out    = w_acc_sh[DW-1:0];
        if (w_acc_sh > OUT_MAX)      w_out = OUT_MAX[DW-1:0];
        else if (w_acc_sh < OUT_MIN) w_out = OUT_MIN[DW-1:0];
    end
`else
    always_comb begin
        w_out = r_acc[SHIFT +: DW];
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Delay line, hold register, overrun flag, accumulator and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(TAPS); i++) r_dly[i] <= '0;
            r_phase    <= 1'b0;
            r_hold_vld <= 1'b0;
            r_hold_dat <= '0;
            r_acc      <= '0;
            r_prod     <= '0;
            r_k        <= '0;
            r_busy     <= 1'b0;
            r_vld_out  <= 1'b0;
            r_dat_out  <= '0;
            r_ovr      <= 1'b0;
        end else begin
            r_vld_out <= 1'b0;
            if (w_shift) begin
                r_dly[0] <= w_shift_dat;
                for (int i = 1; i < int'(TAPS); i++) r_dly[i] <= r_dly[i-1];
                r_phase <= ~r_phase;
            end
            if (w_hold_cap) begin
                r_hold_vld <= 1'b1;
                r_hold_dat <= dat_in;
            end else if (w_shift && r_hold_vld) begin
                r_hold_vld <= 1'b0;
            end
            if (w_drop)       r_ovr <= 1'b1;
            else if (ovr_clr) r_ovr <= 1'b0;
            if (w_start) begin
                r_acc  <= '0;
                r_prod <= '0;
                r_k    <= '0;
            end else if (w_mac) begin
                r_acc <= r_acc + r_prod;
                if (!r_k[3]) r_prod <= w_term;
                r_k <= r_k + 4'd1;
            end
            if (w_done) begin
                r_dat_out <= w_out;
                r_vld_out <= 1'b1;
            end
            r_busy <= (w_state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_cic_comp_mac_seq.sv
// tb_cic_comp_mac_seq: directed and randomized checks of cic_comp_mac_seq
// against a sample-level reference model (direct tap sum, latency countdown).
module tb_cic_comp_mac_seq;

    logic              clk;
    logic              rst;
    logic              clk_vld_in;
    logic signed [34:0] dat_in;
    logic              ovr_clr;
    logic              busy;
    logic              clk_vld_out;
    logic signed [34:0] dat_out;
    logic              ovr_flag;

    cic_comp_mac_seq dut (
        .clk        (clk),
        .rst        (rst),
        .clk_vld_in (clk_vld_in),
        .dat_in     (dat_in),
        .ovr_clr    (ovr_clr),
        .busy       (busy),
        .clk_vld_out(clk_vld_out),
        .dat_out    (dat_out),
        .ovr_flag   (ovr_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic signed [34:0] P30  = 35'sh0_4000_0000;
    localparam logic signed [34:0] PMAX = 35'sh3_FFFF_FFFF;
    localparam logic signed [34:0] PMIN = 35'sh4_0000_0000;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic signed [34:0] m_d [15];
    bit                 m_phase;
    bit                 m_hold_vld;
    logic signed [34:0] m_hold;
    int                 m_rem;
    logic signed [34:0] m_pend;
    logic signed [34:0] m_dat;
    bit                 m_vld;
    bit                 m_ovr;
    logic signed [34:0] q_out [$];

    int c_tab [8] = '{6421026, 1088314, 34811522, 8641811, 116533699, 53216433, 356375486, 628155438};
    bit n_tab [8] = '{1, 1, 0, 0, 1, 1, 0, 0};

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [34:0] ref_out();
        logic signed [95:0] s;
        logic signed [95:0] t;
        logic signed [95:0] sh;
        s = '0;
        for (int k = 0; k < 7; k++) begin
            t = (96'(m_d[k]) + 96'(m_d[14-k])) * 96'(c_tab[k]);
            if (n_tab[k]) s = s - t;
            else          s = s + t;
        end
        s  = s + 96'(m_d[7]) * 96'(c_tab[7]);
        sh = s >>> 30;
`ifdef CIC_COMP_SAT_EN
        if (sh > 96'(PMAX)) return PMAX;
        if (sh < 96'(PMIN)) return PMIN;
`endif
        return sh[34:0];
    endfunction

    task automatic m_shift(input logic signed [34:0] x);
        for (int i = 14; i > 0; i--) m_d[i] = m_d[i-1];
        m_d[0]  = x;
        m_phase = ~m_phase;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 15; i++) m_d[i] = '0;
        m_phase = 0; m_hold_vld = 0; m_hold = '0; m_rem = 0;
        m_pend = '0; m_dat = '0; m_vld = 0; m_ovr = 0;
    endtask

    // One clock: drive inputs, advance the model at the edge, compare just after it.
    task automatic step(input bit v, input logic signed [34:0] x, input bit clr, input bit r);
        bit drop;
        bit trig;
        clk_vld_in = v; dat_in = x; ovr_clr = clr; rst = r;
        @(posedge clk);
        drop = 0;
        if (r) begin
            m_reset();
        end else begin
            m_vld = 0;
            if (m_rem == 0) begin
                if (m_hold_vld) begin
                    m_shift(m_hold);
                    m_hold_vld = 0;
                    if (v) begin m_hold = x; m_hold_vld = 1; end
                end else if (v) begin
                    trig = m_phase;
                    m_shift(x);
                    if (trig) begin m_pend = ref_out(); m_rem = 10; end
                end
            end else begin
                if (m_rem == 1) begin
                    m_dat = m_pend; m_vld = 1;
                    if (m_hold_vld) begin m_shift(m_hold); m_hold_vld = 0; end
                    if (v) begin m_hold = x; m_hold_vld = 1; end
                end else if (v) begin
                    if (!m_hold_vld) begin m_hold = x; m_hold_vld = 1; end
                    else drop = 1;
                end
                m_rem--;
            end
            if (drop)     m_ovr = 1;
            else if (clr) m_ovr = 0;
        end
        #1;
        chk("busy", busy, 64'(m_rem != 0));
        chk("clk_vld_out", clk_vld_out, 64'(m_vld));
        chk("dat_out", dat_out, m_dat);
        chk("ovr_flag", ovr_flag, 64'(m_ovr));
        if (clk_vld_out === 1'b1) q_out.push_back(dat_out);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, '0, 0, 1);
        step(1, P30, 0, 1);
        step(0, '0, 0, 0);
    endtask

    longint exp_imp [9] = '{-6421026, 34811522, -116533699, 356375486, 356375486,
                            -116533699, 34811522, -6421026, 0};

    initial begin
        bit seen_busy;
        int gap;
        logic signed [34:0] x;
        m_reset();
        clk_vld_in = 0; dat_in = '0; ovr_clr = 0; rst = 1;

        // Reset state
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_vld", clk_vld_out, 0);
        chk("rst_dat", dat_out, 0);
        chk("rst_ovr", ovr_flag, 0);

        // Impulse response
        q_out.delete();
        for (int n = 0; n < 19; n++) begin
            step(1, (n == 1) ? P30 : 35'sd0, 0, 0);
            idle(7);
        end
        idle(12);
        chk("imp_count", q_out.size(), 9);
        for (int i = 0; i < 9 && i < q_out.size(); i++) chk("imp_val", q_out[i], exp_imp[i]);

        // DC gain
        do_reset();
        q_out.delete();
        for (int n = 0; n < 20; n++) begin
            step(1, P30, 0, 0);
            idle(7);
        end
        idle(12);
        chk("dc_count", q_out.size(), 10);
        for (int i = 7; i < 10 && i < q_out.size(); i++) chk("dc_val", q_out[i], 64'sd1073294132);

        // Reset mid-sequence (dat_out currently non-zero from the DC run)
        step(1, P30, 0, 0);
        idle(6);
        step(1, P30, 0, 0);
        idle(4);
        step(0, '0, 0, 1);
        chk("abort_busy", busy, 0);
        chk("abort_vld", clk_vld_out, 0);
        chk("abort_dat", dat_out, 0);
        seen_busy = 0;
        step(1, P30, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(0, '0, 0, 0);
            if (busy || clk_vld_out) seen_busy = 1;
        end
        chk("abort_phase0", 64'(seen_busy), 0);

        // Overrun: hold at E0+2, drop at E0+3, then clear
        do_reset();
        step(1, 35'sd5, 0, 0);
        idle(6);
        step(1, 35'sd7, 0, 0);
        step(0, '0, 0, 0);
        step(1, 35'sd11, 0, 0);
        step(1, 35'sd13, 0, 0);
        chk("ovr_set", ovr_flag, 1);
        idle(10);
        chk("ovr_sticky", ovr_flag, 1);
        step(0, '0, 1, 0);
        chk("ovr_clr", ovr_flag, 0);
        // Set and clear on the same edge: set wins
        step(1, 35'sd1, 0, 0);
        idle(2);
        step(1, 35'sd2, 0, 0);
        step(1, 35'sd3, 1, 0);
        chk("ovr_set_wins", ovr_flag, 1);
        idle(14);

        // Saturation / wrap with full-scale line
        do_reset();
        q_out.delete();
        step(1, '0, 0, 0);
        idle(11);
        for (int j = 0; j < 15; j++) begin
            int idx;
            int k;
            idx = 14 - j;
            k   = (idx > 7) ? 14 - idx : idx;
            step(1, n_tab[k] ? PMIN : PMAX, 0, 0);
            idle(11);
        end
        chk("sat_count", q_out.size(), 8);
`ifdef CIC_COMP_SAT_EN
        chk("sat_val", dat_out, 64'sd17179869183);
`else
        chk("sat_val", dat_out, -64'sd5842426050);
`endif

        // Randomized traffic with occasional bursts, clears and resets
        do_reset();
        gap = 1;
        for (int c = 0; c < 4000; c++) begin
            bit v;
            gap--;
            v = (gap == 0);
            if (v) gap = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 12);
            case ($urandom_range(0, 3))
                0:       x = ($urandom_range(0, 1) == 1) ? PMAX : PMIN;
                default: x = 35'({$urandom, $urandom});
            endcase
            step(v, x, ($urandom_range(0, 15) == 0), ($urandom_range(0, 999) == 0));
        end
        idle(12);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
